// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the pipelined asynchronous-SRAM controller.
package sram_ctrl_pkg;

    // Access issued on the previous cycle; TURN is the bus-turnaround bubble.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_TURN = 2'd3
    } state_t;

    localparam int SRAM_CTRL_MAX_DQ_STAGES = 3;
    localparam int SRAM_CTRL_DEF_DATA_W    = 16;

endpackage

// File: rtl/sram_ctrl_rd_pipe.sv
// DQ input register chain with a matching valid delay line. The final data
// stage only loads when a tagged sample reaches it, so the output holds the
// last read result between responses.
module sram_ctrl_rd_pipe
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_W    = SRAM_CTRL_DEF_DATA_W,
    parameter int DQ_STAGES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] dq_in,
    input  logic              tag_in,
    output logic [DATA_W-1:0] data_out,
    output logic              vld_out
);

    if (DQ_STAGES < 1 || DQ_STAGES > SRAM_CTRL_MAX_DQ_STAGES) begin : g_bad_stages
        $error("sram_ctrl_rd_pipe: DQ_STAGES out of range");
    end

    logic [DATA_W-1:0] dq_p   [DQ_STAGES];
    logic              vld_p  [DQ_STAGES];
    logic [DATA_W-1:0] dq_nxt [DQ_STAGES];
    logic              vld_nxt[DQ_STAGES];

    // Input of each stage: pins for stage 0, previous stage otherwise.
    always_comb begin
        dq_nxt[0]  = dq_in;
        vld_nxt[0] = tag_in;
        for (int i = 1; i < DQ_STAGES; i++) begin
            dq_nxt[i]  = dq_p[i-1];
            vld_nxt[i] = vld_p[i-1];
        end
    end

    // Shift samples and tags; the last data stage captures only tagged samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DQ_STAGES; i++) begin
                vld_p[i] <= 1'b0;
                dq_p[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < DQ_STAGES; i++) begin
                vld_p[i] <= vld_nxt[i];
                if (i < DQ_STAGES - 1 || vld_nxt[i])
                    dq_p[i] <= dq_nxt[i];
            end
        end
    end

    assign data_out = dq_p[DQ_STAGES-1];
    assign vld_out  = vld_p[DQ_STAGES-1];

endmodule

// File: rtl/sram_ctrl_pipelined.sv
// Avalon-MM slave for asynchronous external SRAM with registered pins,
// pipelined reads (latency 1+DQ_STAGES) and readdatavalid.
// Optional feature macro: SRAM_CTRL_TURNAROUND_EN -- when defined, a write
// following a read is stalled one cycle (TURN) so the SRAM releases DQ first.
module sram_ctrl_pipelined
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W    = 18,
    parameter int DATA_W    = SRAM_CTRL_DEF_DATA_W,
    parameter int BE_W      = DATA_W / 8,
    parameter int DQ_STAGES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [BE_W-1:0]   byteenable,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write,
    input  logic [DATA_W-1:0] writedata,
    output logic              waitrequest,
    output logic [DATA_W-1:0] readdata,
    output logic              readdatavalid,
    inout  wire  [DATA_W-1:0] SRAM_DQ,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic [BE_W-1:0]   SRAM_BE_N,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N
);

    if (DATA_W % 8 != 0 || BE_W != DATA_W / 8) begin : g_bad_width
        $error("sram_ctrl_pipelined: DATA_W must be a multiple of 8 and BE_W = DATA_W/8");
    end

    state_t            state;
    logic              stall;
    logic              accept;
    logic [DATA_W-1:0] wdata_p1;

`ifdef SRAM_CTRL_TURNAROUND_EN
    // A write right after a read waits one cycle for the SRAM to release DQ.
    assign stall = (state == ST_RD) && chipselect && write && !reset;
`else
    assign stall = 1'b0;
`endif

    assign waitrequest = stall;
    // Write wins when read and write are both asserted.
    assign accept      = chipselect && (read || write) && !stall;

    // FSM and pin registers: pins reflect the access accepted last cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            SRAM_ADDR <= '0;
            SRAM_BE_N <= '1;
            SRAM_CE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            SRAM_WE_N <= 1'b1;
        end else begin
            SRAM_BE_N <= '1;
            SRAM_CE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            SRAM_WE_N <= 1'b1;
            if (accept) begin
                state     <= write ? ST_WR : ST_RD;
                SRAM_ADDR <= address;
                SRAM_BE_N <= ~byteenable;
                SRAM_CE_N <= 1'b0;
                SRAM_OE_N <= write;
                SRAM_WE_N <= !write;
            end else if (stall) begin
                state <= ST_TURN;
            end else begin
                state <= ST_IDLE;
            end
        end
    end

    // Write data is captured alongside the pins; it needs no reset.
    always_ff @(posedge clk) begin
        if (accept && write)
            wdata_p1 <= writedata;
    end

    // Drive DQ only during the write strobe; reset aborts it via SRAM_WE_N.
    assign SRAM_DQ = SRAM_WE_N ? {DATA_W{1'bz}} : wdata_p1;

    // A read pin cycle is exactly when OE is low; that sample is tagged valid.
    sram_ctrl_rd_pipe #(
        .DATA_W   (DATA_W),
        .DQ_STAGES(DQ_STAGES)
    ) u_rd_pipe (
        .clk     (clk),
        .reset   (reset),
        .dq_in   (SRAM_DQ),
        .tag_in  (!SRAM_OE_N),
        .data_out(readdata),
        .vld_out (readdatavalid)
    );

endmodule

// File: tb/tb_sram_ctrl_pipelined.sv
// Bench for sram_ctrl_pipelined: instance A (16-bit, DQ_STAGES=1) and
// instance B (32-bit, DQ_STAGES=3), each with a behavioural async SRAM.
// Honors SRAM_CTRL_TURNAROUND_EN in its turnaround expectations.
module tb_sram_ctrl_pipelined;

    localparam int SA = 1;
    localparam int SB = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Instance A signals
    logic [17:0] a_address;
    logic [1:0]  a_be;
    logic        a_cs, a_rd, a_wr;
    logic [15:0] a_wdata;
    logic        a_wait;
    logic [15:0] a_rdata;
    logic        a_rdv;
    wire  [15:0] a_dq;
    logic [17:0] a_sa;
    logic [1:0]  a_be_n;
    logic        a_ce_n, a_oe_n, a_we_n;

    // Instance B signals
    logic [17:0] b_address;
    logic [3:0]  b_be;
    logic        b_cs, b_rd, b_wr;
    logic [31:0] b_wdata;
    logic        b_wait;
    logic [31:0] b_rdata;
    logic        b_rdv;
    wire  [31:0] b_dq;
    logic [17:0] b_sa;
    logic [3:0]  b_be_n;
    logic        b_ce_n, b_oe_n, b_we_n;

    sram_ctrl_pipelined #(.ADDR_W(18), .DATA_W(16), .DQ_STAGES(SA)) dut_a (
        .clk(clk), .reset(reset), .address(a_address), .byteenable(a_be),
        .chipselect(a_cs), .read(a_rd), .write(a_wr), .writedata(a_wdata),
        .waitrequest(a_wait), .readdata(a_rdata), .readdatavalid(a_rdv),
        .SRAM_DQ(a_dq), .SRAM_ADDR(a_sa), .SRAM_BE_N(a_be_n),
        .SRAM_CE_N(a_ce_n), .SRAM_OE_N(a_oe_n), .SRAM_WE_N(a_we_n)
    );

    sram_ctrl_pipelined #(.ADDR_W(18), .DATA_W(32), .DQ_STAGES(SB)) dut_b (
        .clk(clk), .reset(reset), .address(b_address), .byteenable(b_be),
        .chipselect(b_cs), .read(b_rd), .write(b_wr), .writedata(b_wdata),
        .waitrequest(b_wait), .readdata(b_rdata), .readdatavalid(b_rdv),
        .SRAM_DQ(b_dq), .SRAM_ADDR(b_sa), .SRAM_BE_N(b_be_n),
        .SRAM_CE_N(b_ce_n), .SRAM_OE_N(b_oe_n), .SRAM_WE_N(b_we_n)
    );

    // Behavioural SRAMs (16 words each, low address bits)
    logic [15:0] mem_a [16] = '{default: '0};
    logic [31:0] mem_b [16] = '{default: '0};

    assign a_dq = (!a_ce_n && !a_oe_n && a_we_n) ? mem_a[a_sa[3:0]] : 16'bz;
    assign b_dq = (!b_ce_n && !b_oe_n && b_we_n) ? mem_b[b_sa[3:0]] : 32'bz;

    always @(posedge clk) begin
        if (!a_ce_n && !a_we_n)
            for (int i = 0; i < 2; i++)
                if (!a_be_n[i]) mem_a[a_sa[3:0]][8*i +: 8] <= a_dq[8*i +: 8];
    end

    always @(posedge clk) begin
        if (!b_ce_n && !b_we_n)
            for (int i = 0; i < 4; i++)
                if (!b_be_n[i]) mem_b[b_sa[3:0]][8*i +: 8] <= b_dq[8*i +: 8];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: expected read data and the cycle its readdatavalid is due
    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;

    always @(negedge clk) begin
        if (a_rdv === 1'b1) begin
            if (q_a.size() == 0) begin
                check("a_rdv_unexpected", 32'(a_rdv), 32'h0);
            end else begin
                ea = q_a.pop_front();
                check("a_readdata", 32'(a_rdata), ea.data);
                check("a_rdv_cycle", 32'(cyc), 32'(ea.due));
            end
        end else if (q_a.size() != 0 && q_a[0].due <= cyc) begin
            check("a_rdv_missing", 32'(a_rdv), 32'h1);
            ea = q_a.pop_front();
        end
    end

    always @(negedge clk) begin
        if (b_rdv === 1'b1) begin
            if (q_b.size() == 0) begin
                check("b_rdv_unexpected", 32'(b_rdv), 32'h0);
            end else begin
                eb = q_b.pop_front();
                check("b_readdata", b_rdata, eb.data);
                check("b_rdv_cycle", 32'(cyc), 32'(eb.due));
            end
        end else if (q_b.size() != 0 && q_b[0].due <= cyc) begin
            check("b_rdv_missing", 32'(b_rdv), 32'h1);
            eb = q_b.pop_front();
        end
    end

    // Present a request just after a posedge and hold it until accepted.
    // Returns #1 after the acceptance edge, i.e. inside the pin cycle.
    task automatic req(input bit sel_b, input bit wr, input bit rd, input logic [17:0] ad,
                       input logic [31:0] wd, input logic [3:0] be, input logic [31:0] exp_rd);
        bit done;
        done = 1'b0;
        if (sel_b) begin
            b_cs = 1'b1; b_wr = wr; b_rd = rd; b_address = ad; b_wdata = wd; b_be = be;
        end else begin
            a_cs = 1'b1; a_wr = wr; a_rd = rd; a_address = ad; a_wdata = wd[15:0]; a_be = be[1:0];
        end
        for (int t = 0; t < 6 && !done; t++) begin
            @(negedge clk);
            if ((sel_b ? b_wait : a_wait) === 1'b0) begin
                exp_t e;
                done = 1'b1;
                if (rd && !wr) begin
                    e.data = exp_rd;
                    e.due  = cyc + 1 + (sel_b ? SB : SA);
                    if (sel_b) q_b.push_back(e);
                    else       q_a.push_back(e);
                end
            end
            @(posedge clk); #1;
        end
        check("req_accepted", 32'(done), 32'h1);
    endtask

    task automatic idle(input int n);
        a_cs = 1'b0; a_rd = 1'b0; a_wr = 1'b0;
        b_cs = 1'b0; b_rd = 1'b0; b_wr = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        bit          wr;
        bit          rd;
        logic [17:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [10];

    initial begin
        // Table for instance A; 0x10 already holds 0xA5C3, other words are 0
        vecs[0] = '{1'b1, 1'b0, 18'h11, 16'h1234, 2'b01, 16'h0000};
        vecs[1] = '{1'b0, 1'b1, 18'h11, 16'h0000, 2'b11, 16'h0034};
        vecs[2] = '{1'b1, 1'b0, 18'h11, 16'hABCD, 2'b10, 16'h0000};
        vecs[3] = '{1'b0, 1'b1, 18'h11, 16'h0000, 2'b11, 16'hAB34};
        vecs[4] = '{1'b0, 1'b1, 18'h10, 16'h0000, 2'b00, 16'hA5C3};
        vecs[5] = '{1'b1, 1'b0, 18'h12, 16'hFFFF, 2'b11, 16'h0000};
        vecs[6] = '{1'b0, 1'b1, 18'h12, 16'h0000, 2'b11, 16'hFFFF};
        vecs[7] = '{1'b1, 1'b1, 18'h13, 16'h5A5A, 2'b11, 16'h0000};
        vecs[8] = '{1'b0, 1'b1, 18'h13, 16'h0000, 2'b11, 16'h5A5A};
        vecs[9] = '{1'b0, 1'b1, 18'h11, 16'h0000, 2'b11, 16'hAB34};

        // 1. Reset with a read request held
        reset = 1'b1;
        a_cs = 1'b1; a_rd = 1'b1; a_wr = 1'b0; a_address = 18'h3; a_be = 2'b11; a_wdata = 16'h0;
        b_cs = 1'b1; b_rd = 1'b1; b_wr = 1'b0; b_address = 18'h3; b_be = 4'hF; b_wdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_a_strobes", 32'({a_ce_n, a_oe_n, a_we_n}), 32'h7);
            check("rst_a_be_n", 32'(a_be_n), 32'h3);
            check("rst_a_rdv", 32'(a_rdv), 32'h0);
            check("rst_a_dq_z", 32'(a_dq === 16'hzzzz), 32'h1);
            check("rst_a_wait", 32'(a_wait), 32'h0);
            check("rst_b_strobes", 32'({b_ce_n, b_oe_n, b_we_n}), 32'h7);
            check("rst_b_rdv", 32'(b_rdv), 32'h0);
            check("rst_b_dq_z", 32'(b_dq === 32'hzzzzzzzz), 32'h1);
        end
        check("rst_a_addr", 32'(a_sa), 32'h0);
        check("rst_a_readdata", 32'(a_rdata), 32'h0);
        reset = 1'b0;
        idle(0);
        @(posedge clk); #1;

        // 2. Write 0xA5C3 then read it back
        req(1'b0, 1'b1, 1'b0, 18'h10, 32'hA5C3, 4'b0011, 32'h0);
        check("t2_we_low", 32'(a_we_n), 32'h0);
        check("t2_dq", 32'(a_dq), 32'hA5C3);
        check("t2_be_n", 32'(a_be_n), 32'h0);
        check("t2_addr", 32'(a_sa), 32'h10);
        check("t2_oe_high", 32'(a_oe_n), 32'h1);
        req(1'b0, 1'b0, 1'b1, 18'h10, 32'h0, 4'b0011, 32'hA5C3);
        check("t2_we_one_cycle", 32'(a_we_n), 32'h1);
        check("t2_oe_low", 32'(a_oe_n), 32'h0);
        idle(4);
        check("t2_rdata_hold", 32'(a_rdata), 32'hA5C3);
        check("t2_rdv_low", 32'(a_rdv), 32'h0);

        // Table-driven back-to-back traffic on instance A
        for (int i = 0; i < 10; i++)
            req(1'b0, vecs[i].wr, vecs[i].rd, vecs[i].addr, {16'h0, vecs[i].wdata},
                {2'b00, vecs[i].be}, {16'h0, vecs[i].exp});
        idle(6);

        // 5. Read at N, write presented at N+1
        req(1'b0, 1'b0, 1'b1, 18'h12, 32'h0, 4'b0011, 32'hFFFF);
        a_cs = 1'b1; a_rd = 1'b0; a_wr = 1'b1; a_address = 18'h14; a_wdata = 16'h7E81; a_be = 2'b11;
        @(negedge clk);
`ifdef SRAM_CTRL_TURNAROUND_EN
        check("t5_wait_high", 32'(a_wait), 32'h1);
        @(posedge clk); #1;
        check("t5_turn_strobes", 32'({a_ce_n, a_oe_n, a_we_n}), 32'h7);
        check("t5_turn_dq_z", 32'(a_dq === 16'hzzzz), 32'h1);
        @(negedge clk);
        check("t5_wait_low", 32'(a_wait), 32'h0);
        @(posedge clk); #1;
        idle(0);
        check("t5_we_low", 32'(a_we_n), 32'h0);
        check("t5_dq", 32'(a_dq), 32'h7E81);
`else
        check("t5_no_wait", 32'(a_wait), 32'h0);
        @(posedge clk); #1;
        idle(0);
        check("t5_we_low", 32'(a_we_n), 32'h0);
        check("t5_dq", 32'(a_dq), 32'h7E81);
`endif
        idle(2);
        req(1'b0, 1'b0, 1'b1, 18'h14, 32'h0, 4'b0011, 32'h7E81);
        idle(5);

        // 6. Reset one cycle after a read is accepted
        a_cs = 1'b1; a_rd = 1'b1; a_wr = 1'b0; a_address = 18'h10; a_be = 2'b11;
        @(negedge clk);
        check("t6_accept", 32'(a_wait), 32'h0);
        @(posedge clk); #1;
        check("t6_oe_low", 32'(a_oe_n), 32'h0);
        reset = 1'b1;
        idle(0);
        @(posedge clk); #1;
        reset = 1'b0;
        check("t6_oe_released", 32'(a_oe_n), 32'h1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t6_no_rdv", 32'(a_rdv), 32'h0);
            @(posedge clk); #1;
        end

        // 4. Instance B: fill 0..3, then four back-to-back reads
        for (int i = 0; i < 4; i++)
            req(1'b1, 1'b1, 1'b0, 18'(i), 32'(i), 4'hF, 32'h0);
        for (int i = 0; i < 4; i++)
            req(1'b1, 1'b0, 1'b1, 18'(i), 32'h0, 4'hF, 32'(i));
        idle(8);

        // 3. Instance B: partial-lane write
        req(1'b1, 1'b1, 1'b0, 18'h5, 32'h11223344, 4'b0101, 32'h0);
        check("t3_be_n", 32'(b_be_n), 32'hA);
        check("t3_we_low", 32'(b_we_n), 32'h0);
        check("t3_dq", b_dq, 32'h11223344);
        idle(1);
        check("t3_we_released", 32'(b_we_n), 32'h1);
        check("t3_dq_z", 32'(b_dq === 32'hzzzzzzzz), 32'h1);
        req(1'b1, 1'b0, 1'b1, 18'h5, 32'h0, 4'hF, 32'h00220044);
        idle(8);

        for (int i = 0; i < 20 && (q_a.size() != 0 || q_b.size() != 0); i++) begin
            @(posedge clk); #1;
        end
        check("q_a_drained", 32'(q_a.size()), 32'h0);
        check("q_b_drained", 32'(q_b.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
